// File: rtl/vld_rdy_skid.sv
// vld_rdy_skid: two-entry skid buffer on a valid/ready handshake.
// Every path that crosses the block is registered: rdy_o, vld_o and dat_o
// all come from flops. While the buffer is full, the skid register holds the
// one beat accepted in the cycle before rdy_o could react to rdy_i.
module vld_rdy_skid #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vld_i,
  input  logic [DW-1:0] dat_i,
  output logic          rdy_o,
  output logic          vld_o,
  output logic [DW-1:0] dat_o,
  input  logic          rdy_i,
  output logic [1:0]    cnt_o
);

  // The state encoding equals the occupancy, so cnt_o is the state flops.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] main_q,  main_d;
  logic [DW-1:0] skid_q,  skid_d;
  logic          rdy_q,   rdy_d;
  logic          vld_q,   vld_d;

  logic push;
  logic pop;

  // Handshake events use only registered ready/valid on our side.
  assign push = vld_i & rdy_q;
  assign pop  = vld_q & rdy_i;

  // Next-state, data movement and next-output decode.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          main_d  = dat_i;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          main_d = dat_i;
        end else if (push) begin
          skid_d  = dat_i;
          state_d = TWO;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // rdy_q is low here, so no push can arrive.
        if (pop) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    // Outputs are decoded from the next state and stored in their own flops.
    rdy_d = (state_d != TWO);
    vld_d = (state_d != EMPTY);
  end

  // State, storage and output flops; reset dominates any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
    end
  end

  assign rdy_o = rdy_q;
  assign vld_o = vld_q;
  assign dat_o = main_q;
  assign cnt_o = state_q;

endmodule
